// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter and its read-side companions:
// state encoding, ceil-log2 helper and the write-word field layout.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Ceil-log2 usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // The FIFO word is {id, payload}: the ID field starts right above the payload.
  function automatic int unsigned id_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write port seen by the arbiter.
// master = the arbiter (drives ready and the write bus), slave = producers and FIFO.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned ID_W = clog2(N);

  logic [N-1:0]           req_valid;
  logic [N*DATA_W-1:0]    req_data;
  logic [N-1:0]           req_ready;
  logic                   fifo_full;
  logic                   fifo_wr;
  logic [ID_W+DATA_W-1:0] fifo_w_data;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_w_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_w_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit scanning last+1 .. last (mod N).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    int unsigned cand;
    cand = 0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last) + k) % N;
      if (!any && req[cand[ID_W-1:0]]) begin
        any = 1'b1;
        idx = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers,
// with bounded bursts and the source ID prepended to every written word.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic              clk,
  input logic              reset,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned ID_W  = clog2(N);
  localparam int unsigned CNT_W = clog2(MAX_BURST + 1);

  state_e            state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   last;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              in_grant;
  logic              owner_valid;
  logic              xfer;
  logic [DATA_W-1:0] data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(N)) u_pick (
    .req  (bus.req_valid),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign in_grant    = (state == ST_GRANT);
  assign owner_valid = bus.req_valid[owner];
  assign xfer        = in_grant & owner_valid & ~bus.fifo_full;
  assign cnt_inc     = burst_cnt + CNT_W'(1);

  // Write port and ready: payload only steers fifo_w_data, never a control output.
  always_comb begin
    bus.req_ready   = '0;
    bus.fifo_wr     = 1'b0;
    bus.fifo_w_data = '0;
    if (in_grant) bus.req_ready[owner] = ~bus.fifo_full;
    if (xfer) begin
      bus.fifo_wr                               = 1'b1;
      bus.fifo_w_data[id_lsb(DATA_W) +: ID_W]  = owner;
      bus.fifo_w_data[DATA_W-1:0]               = data_arr[owner];
    end
  end

  assign bus.busy     = in_grant;
  assign bus.grant_id = owner;

  // Grant FSM: hold through full, release on burst limit or when the owner goes idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      last      <= ID_W'(N - 1);
      burst_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner     <= pick_idx;
            last      <= pick_idx;
            burst_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer) burst_cnt <= cnt_inc;
          if (!owner_valid || (xfer && (cnt_inc == CNT_W'(MAX_BURST))))
            state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle vector table, async-reset sequence
// and an integration run against a 4-entry FIFO model.
module tb_fifo_wr_arbiter;

  logic clk;
  logic reset;
  logic full_drv;
  logic use_fifo;
  logic rd_en;

  fifo_wr_arbiter_if #(.N(4), .DATA_W(8)) bus ();

  fifo_wr_arbiter #(.N(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-entry FIFO model for the integration run
  logic [9:0] fmem [4];
  logic [1:0] wp, rp;
  logic [2:0] f_cnt;
  logic       do_w, do_r;
  logic [9:0] drained [$];

  assign do_w = bus.fifo_wr & (f_cnt != 3'd4);
  assign do_r = rd_en & (f_cnt != 3'd0);
  assign bus.fifo_full = use_fifo ? (f_cnt == 3'd4) : full_drv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      f_cnt <= '0;
    end else begin
      if (do_w) begin
        fmem[wp] <= bus.fifo_w_data;
        wp       <= wp + 2'd1;
      end
      if (do_r) begin
        drained.push_back(fmem[rp]);
        rp <= rp + 2'd1;
      end
      f_cnt <= f_cnt + {2'b0, do_w} - {2'b0, do_r};
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic        wr;
    logic [9:0]  wdata;
    logic [3:0]  ready;
    logic        busy;
    logic [1:0]  gid;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic rst, input logic [3:0] v, input logic [31:0] d,
                     input logic f, input logic wr, input logic [9:0] wd,
                     input logic [3:0] rdy, input logic b, input logic [1:0] g);
    vec_t e;
    e.rst = rst; e.valid = v; e.data = d; e.full = f;
    e.wr = wr; e.wdata = wd; e.ready = rdy; e.busy = b; e.gid = g;
    vecs.push_back(e);
  endtask

  initial begin
    int o;
    int prev;
    int wr_cnt;
    bit drain;
    int pcnt [3];
    logic [2:0] acc;

    reset = 1'b1; full_drv = 1'b0; use_fifo = 1'b0; rd_en = 1'b0;
    bus.req_valid = '0; bus.req_data = '0;

    // Reset state, then one requester sending three words
    add(1, 4'b0000, 32'h0, 0, 0, 10'h0,   4'b0000, 0, 2'd0);
    add(1, 4'b0000, 32'h0, 0, 0, 10'h0,   4'b0000, 0, 2'd0);
    add(0, 4'b0001, 32'hA1, 0, 0, 10'h0,   4'b0000, 0, 2'd0);
    add(0, 4'b0001, 32'hA1, 0, 1, 10'h0A1, 4'b0001, 1, 2'd0);
    add(0, 4'b0001, 32'hA2, 0, 1, 10'h0A2, 4'b0001, 1, 2'd0);
    add(0, 4'b0001, 32'hA3, 0, 1, 10'h0A3, 4'b0001, 1, 2'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 10'h0,   4'b0001, 1, 2'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 10'h0,   4'b0000, 0, 2'd0);

    // Round robin with everyone valid: 0,1,2,3,0, four writes each, one bubble between
    add(1, 4'b0000, 32'h0, 0, 0, 10'h0, 4'b0000, 0, 2'd0);
    for (int b = 0; b < 5; b++) begin
      o    = b % 4;
      prev = (b == 0) ? 0 : (b - 1) % 4;
      add(0, 4'b1111, 32'h44332211, 0, 0, 10'h0, 4'b0000, 0, 2'(prev));
      for (int w = 0; w < 4; w++)
        add(0, 4'b1111, 32'h44332211, 0, 1, {2'(o), 8'(17 * (o + 1))}, 4'(1 << o), 1, 2'(o));
    end
    add(0, 4'b0000, 32'h0, 0, 0, 10'h0, 4'b0000, 0, 2'd0);

    // Full for five cycles after two writes; same owner finishes the burst
    add(1, 4'b0000, 32'h0,    0, 0, 10'h0,   4'b0000, 0, 2'd0);
    add(0, 4'b0010, 32'hB100, 0, 0, 10'h0,   4'b0000, 0, 2'd0);
    add(0, 4'b0010, 32'hB100, 0, 1, 10'h1B1, 4'b0010, 1, 2'd1);
    add(0, 4'b0010, 32'hB200, 0, 1, 10'h1B2, 4'b0010, 1, 2'd1);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, 32'hB300, 1, 0, 10'h0, 4'b0000, 1, 2'd1);
    add(0, 4'b0010, 32'hB300, 0, 1, 10'h1B3, 4'b0010, 1, 2'd1);
    add(0, 4'b0010, 32'hB400, 0, 1, 10'h1B4, 4'b0010, 1, 2'd1);
    add(0, 4'b0000, 32'h0,    0, 0, 10'h0,   4'b0000, 0, 2'd1);

    // Owner 2 drops after one word, owner 3 follows
    add(0, 4'b1100, 32'hD1C10000, 0, 0, 10'h0,   4'b0000, 0, 2'd1);
    add(0, 4'b1100, 32'hD1C10000, 0, 1, 10'h2C1, 4'b0100, 1, 2'd2);
    add(0, 4'b1000, 32'hD1C10000, 0, 0, 10'h0,   4'b0100, 1, 2'd2);
    add(0, 4'b1000, 32'hD1C10000, 0, 0, 10'h0,   4'b0000, 0, 2'd2);
    add(0, 4'b1000, 32'hD1C10000, 0, 1, 10'h3D1, 4'b1000, 1, 2'd3);
    add(0, 4'b0000, 32'h0,        0, 0, 10'h0,   4'b1000, 1, 2'd3);
    add(0, 4'b0000, 32'h0,        0, 0, 10'h0,   4'b0000, 0, 2'd3);

    // Owner drops valid while the FIFO is full: grant released
    add(0, 4'b0001, 32'hE1, 0, 0, 10'h0, 4'b0000, 0, 2'd3);
    add(0, 4'b0001, 32'hE1, 1, 0, 10'h0, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 32'h0,  1, 0, 10'h0, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 32'h0,  0, 0, 10'h0, 4'b0000, 0, 2'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset         = vecs[k].rst;
      bus.req_valid = vecs[k].valid;
      bus.req_data  = vecs[k].data;
      full_drv      = vecs[k].full;
      #1;
      chk($sformatf("v%0d.wr", k),    32'(bus.fifo_wr),     32'(vecs[k].wr));
      chk($sformatf("v%0d.wdata", k), 32'(bus.fifo_w_data), 32'(vecs[k].wdata));
      chk($sformatf("v%0d.ready", k), 32'(bus.req_ready),   32'(vecs[k].ready));
      chk($sformatf("v%0d.busy", k),  32'(bus.busy),        32'(vecs[k].busy));
      chk($sformatf("v%0d.gid", k),   32'(bus.grant_id),    32'(vecs[k].gid));
    end

    // Async reset during the third word of requester 2's burst
    @(negedge clk); bus.req_valid = 4'b0100; bus.req_data = 32'h00710000; #1;
    chk("rst.idle_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); #1;
    chk("rst.w1", 32'(bus.fifo_w_data), 32'h271);
    @(negedge clk); bus.req_data = 32'h00720000; #1;
    chk("rst.w2", 32'(bus.fifo_w_data), 32'h272);
    @(negedge clk); bus.req_data = 32'h00730000; #1;
    chk("rst.w3_wr", 32'(bus.fifo_wr), 32'd1);
    chk("rst.w3", 32'(bus.fifo_w_data), 32'h273);
    #2 reset = 1'b1; #1;
    chk("rst.wr_drop", 32'(bus.fifo_wr), 32'd0);
    chk("rst.busy_drop", 32'(bus.busy), 32'd0);
    @(negedge clk); bus.req_valid = 4'b1111; bus.req_data = 32'h44332211; #1;
    chk("rst.hold_wr", 32'(bus.fifo_wr), 32'd0);
    chk("rst.hold_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rst.rel_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); #1;
    chk("rst.first_gid", 32'(bus.grant_id), 32'd0);
    chk("rst.first_busy", 32'(bus.busy), 32'd1);
    chk("rst.first_w", 32'(bus.fifo_w_data), 32'h011);

    // Integration: three producers x four words into a 4-entry FIFO
    @(negedge clk); bus.req_valid = '0; use_fifo = 1'b1; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    wr_cnt = 0; drain = 1'b0;
    for (int i = 0; i < 3; i++) pcnt[i] = 0;
    for (int cyc = 0; cyc < 300 && drained.size() < 12; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bus.req_valid[i]         = (pcnt[i] < 4);
        bus.req_data[i*8 +: 8]   = 8'(16 * i + pcnt[i]);
      end
      bus.req_valid[3] = 1'b0;
      rd_en = drain;
      #1;
      for (int i = 0; i < 3; i++) acc[i] = bus.req_valid[i] & bus.req_ready[i];
      if (bus.fifo_wr) wr_cnt++;
      if (!drain && bus.fifo_full) begin
        chk("int.writes_at_full", 32'(wr_cnt), 32'd4);
        drain = 1'b1;
      end
      for (int i = 0; i < 3; i++) if (acc[i]) pcnt[i]++;
    end
    @(negedge clk); rd_en = 1'b0; bus.req_valid = '0;
    chk("int.saw_full", 32'(drain), 32'd1);
    chk("int.drained_count", 32'(drained.size()), 32'd12);
    for (int k = 0; k < drained.size() && k < 12; k++)
      chk($sformatf("int.word%0d", k), 32'(drained[k]),
          32'({2'(k / 4), 8'(16 * (k / 4) + (k % 4))}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port among N producers. Each producer presents words on a valid/ready handshake. The arbiter grants one producer at a time for a burst of at most MAX_BURST words and drives the FIFO's `wr`/`w_data`, honouring `full`. It prepends the source ID to each word so the consumer side can demultiplex; the FIFO instance is sized with `B = ID_W + DATA_W`.

## Interface
- `N`, 4: number of requesters, ≥ 2.
- `DATA_W`, 8: payload bits per word.
- `MAX_BURST`, 4: maximum words per grant, ≥ 1.
- `ID_W` (localparam), `$clog2(N)`: source-ID width.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  N  bit i: requester i has a word.
- `req_data`  in  N*DATA_W  word of requester i at bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  N  bit i: word of requester i accepted this cycle if valid.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_w_data`  out  ID_W+DATA_W  `{owner_id, payload}`; all zero when `fifo_wr` = 0.
- `grant_id`  out  ID_W  current/last owner.
- `busy`  out  1  a grant is held (state GRANT).

## Operation
- **State machine:** two states, IDLE and GRANT. Registers: `state`, `owner` (ID_W), `last` (ID_W), `burst_cnt` (width `$clog2(MAX_BURST+1)`).
- **IDLE:**
  - If any `req_valid` bit is set, pick the first set bit scanning `last+1, last+2, …, last` (mod N).
  - Load `owner` and `last` with that index, clear `burst_cnt`, go to GRANT.
  - No transfers occur in IDLE.
- **GRANT:**
  - `req_ready[owner] = ~fifo_full`; all other `req_ready` bits are 0.
  - Transfer = `req_valid[owner] & ~fifo_full`. On a transfer, `fifo_wr` = 1, `fifo_w_data = {owner, req_data[owner]}`, and `burst_cnt` increments.
  - Release to IDLE when the transfer brings `burst_cnt` to MAX_BURST, or when `req_valid[owner]` = 0.
  - The releasing cycle still performs its transfer if one qualifies.
- **Full:**
  - While `fifo_full` = 1 the grant is held indefinitely: no ready, no write, counter frozen.
  - If the owner drops valid while the FIFO is full, the grant is released.
- **Producer rule:** once valid is asserted, `req_data` must stay stable until ready.
- **Outputs:** `fifo_wr`, `req_ready` and `fifo_w_data` are combinational from registered state plus `req_valid` and `fifo_full`. They contain no combinational path from `req_data` to any control output.
- **Reset (async):** state = IDLE, `owner` = 0, `last` = N-1 (requester 0 wins first), `burst_cnt` = 0.
  - `fifo_wr` = 0, `req_ready` = 0, `fifo_w_data` = 0, `grant_id` = 0, `busy` = 0.
  - Reset mid-burst drops the grant immediately; no write occurs in a reset cycle.

## Timing
- Arbitration latency: 1 cycle from a valid request seen in IDLE to the first possible transfer.
- Sustained throughput with one active requester: MAX_BURST words per MAX_BURST+1 cycles.
- Release to the next grant: 1 IDLE bubble cycle.
- The `fifo_wr` to FIFO write timing is the same-edge behaviour of the FIFO: the word is written on the rising edge where `fifo_wr` = 1 and `fifo_full` = 0.
- `busy` and `grant_id` are registered and change on the edge that enters or leaves GRANT.

## Structure
- Shared package `fifo_arb_pkg`:
  - state encoding (IDLE = 0, GRANT = 1);
  - the `clog2` helper;
  - the `fifo_w_data` field layout constant (ID in the MSBs).
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: `req` (N), `last` (ID_W).
  - Outputs: `any`, `idx` (ID_W).
  - Reused by the planned read-side demux scheduler.

## Test plan
- **Reset, single requester:** after reset, `req_valid` = 4'b0001 with 3 words 0xA1, 0xA2, 0xA3 → first `fifo_wr` in cycle 2. `fifo_w_data` = {2'd0, 0xA1}, {2'd0, 0xA2}, {2'd0, 0xA3} on consecutive cycles, then release when valid drops.
- **Round-robin fairness:** all 4 requesters continuously valid, MAX_BURST = 4 → grant order 0, 1, 2, 3, 0. Each burst is exactly 4 writes separated by 1 idle cycle.
- **Full backpressure:** `fifo_full` asserted mid-burst after 2 writes for 5 cycles → `req_ready` = 0 and `fifo_wr` = 0 for 5 cycles. The same owner then completes the remaining 2 words with no re-arbitration.
- **Owner drop:** requester 2 drops valid after 1 word while requester 3 is valid → requester 2 is released, requester 3 is granted next, and `last` = 3.
- **Async reset mid-burst:** assert `reset` during the owner's 3rd word → `fifo_wr` = 0 and `busy` = 0 immediately. After release, requester 0 is granted first.
- **FIFO integration:** arbiter plus FIFO (W = 2, 4 entries), 3 requesters each sending 4 words → FIFO reports `full` after 4 writes. Draining recovers all 12 words in grant order, each with the correct ID.
